led_sequencer: RTL

- Command-driven pattern sequencer that owns the 8-LED bank (on-board and PMOD LEDs) and decides what it displays.
- Accepts mode commands over a valid/ready handshake and runs a prescaled step engine with count, scan, blink and off modes.
- Runs for N steps or indefinitely, and reports completion.
- Sits between the system control logic and the LED output pins, in the PLL-generated clock domain.

---
 rtl/led_sequencer.sv | 83 ++++++++
 1 files changed

// File: rtl/led_sequencer.sv
// led_sequencer: command-driven 8-LED pattern engine (count/scan/blink/off) with a prescaled step tick.
module led_sequencer #(
    parameter int TICK_DIV   = 8388608,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [7:0] cmd_steps,
    output logic [7:0] led_out,
    output logic       busy,
    output logic       done,
    output logic       tick_out
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {M_COUNT, M_SCAN, M_BLINK, M_OFF} mode_t;
    state_t        state, state_n;
    mode_t         mode, mode_n;
    logic [7:0]    pattern, pattern_n, scan_next, adv;
    logic [PW-1:0] pre, pre_n;
    logic [7:0]    steps_left, steps_n;
    logic          dir_right, dir_n, done_n, tick, accept;
    assign tick      = (state == RUN) && (pre == LAST);
    assign cmd_ready = !rst && ((state == IDLE) || (steps_left == 8'd0));
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = state == RUN;
    assign tick_out  = tick;
    assign led_out   = pattern ^ {8{ACTIVE_LOW}};
    assign scan_next = dir_right ? pattern >> 1 : pattern << 1;
    assign adv       = mode == M_COUNT ? pattern + 8'd1 : mode == M_SCAN ? scan_next : ~pattern;
    // accept has priority over a coincident tick: the tick is dropped and the prescaler restarts
    always_comb begin
        state_n   = state;
        mode_n    = mode;
        pattern_n = pattern;
        pre_n     = (state == RUN && !tick) ? pre + PW'(1) : '0;
        steps_n   = steps_left;
        dir_n     = dir_right;
        done_n    = 1'b0;
        if (accept) begin
            mode_n    = mode_t'(cmd_mode);
            pre_n     = '0;
            dir_n     = 1'b0;
            steps_n   = mode_t'(cmd_mode) == M_OFF ? 8'd0 : cmd_steps;
            state_n   = mode_t'(cmd_mode) == M_OFF ? IDLE : RUN;
            done_n    = mode_t'(cmd_mode) == M_OFF;
            pattern_n = mode_t'(cmd_mode) == M_BLINK ? 8'hFF : mode_t'(cmd_mode) == M_SCAN ? 8'h01 : 8'h00;
        end else if (tick) begin
            pattern_n = adv;
            if (mode == M_SCAN && scan_next == (dir_right ? 8'h01 : 8'h80))
                dir_n = !dir_right;
            if (steps_left != 8'd0)
                steps_n = steps_left - 8'd1;
            if (steps_left == 8'd1) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mode       <= M_COUNT;
            pattern    <= 8'h00;
            pre        <= '0;
            steps_left <= 8'd0;
            dir_right  <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            mode       <= mode_n;
            pattern    <= pattern_n;
            pre        <= pre_n;
            steps_left <= steps_n;
            dir_right  <= dir_n;
            done       <= done_n;
        end
    end
endmodule
